// File: rtl/hash_round_engine.sv
// -----------------------------------------------------------------------------
// hash_round_engine
//
// Sequential driver for the 4-bit-lane round stage of the lightweight hash.
// Holds the 8 x 4-bit chaining state h, absorbs message bytes over a
// valid/ready handshake and applies ROUNDS rounds per byte, one per clock.
// The 32-bit digest {h[7],...,h[0]} is presented once the last byte is done.
//
// Parameters
//   ROUNDS        rounds applied per absorbed byte (1..255)
//   IV            initial chaining value loaded on start (nibble i = IV[4i+3:4i])
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a new hash (honoured only in IDLE or DONE)
//   msg_valid     msg_data / msg_last are valid
//   msg_data      message byte
//   msg_last      this byte is the final byte of the message
//   msg_ready     engine accepts a byte this cycle (ABSORB)
//   busy          high in ABSORB and ROUND
//   digest        current chaining state, meaningful while digest_valid = 1
//   digest_valid  high in DONE
// -----------------------------------------------------------------------------
module hash_round_engine #(
    parameter int          ROUNDS = 16,
    parameter logic [31:0] IV     = 32'h0123_4567
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        msg_valid,
    input  logic [7:0]  msg_data,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic        busy,
    output logic [31:0] digest,
    output logic        digest_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ABSORB = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Counter value during the cycle whose edge applies the final round.
    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    // Fixed 4-bit substitution box.
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // 4-bit circular left rotate: the upper half of {x,x} << amt.
    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] amt);
        logic [7:0] d;
        d = {x, x} << amt;
        return d[7:4];
    endfunction

    // One round: lane i takes lane (i+2) mod 8, mixed with s, rotated by i/2.
    function automatic logic [31:0] round_fn(input logic [31:0] h, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = rotl4(h[4*((i + 2) % 8) +: 4] ^ s, 2'(i / 2));
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] h_q, h_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;

    logic [3:0]  m_r;
    logic [3:0]  s_in;
    logic [31:0] h_round;

    // Even rounds mix in the low nibble of the byte, odd rounds the high one.
    assign m_r     = cnt_q[0] ? byte_q[7:4] : byte_q[3:0];
    assign s_in    = sbox4(h_q[3:0] ^ m_r);
    assign h_round = round_fn(h_q, s_in);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // A byte presented alongside start is not consumed here.
                if (start) begin
                    h_d     = IV;
                    state_d = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (msg_valid) begin
                    byte_d  = msg_data;
                    last_d  = msg_last;
                    cnt_d   = 8'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                h_d   = h_round;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == LAST_RND) begin
                    state_d = last_q ? ST_DONE : ST_ABSORB;
                end
            end
            default: begin
                if (start) begin
                    h_d     = IV;
                    state_d = ST_ABSORB;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
        end
    end

    assign msg_ready    = (state_q == ST_ABSORB);
    assign busy         = (state_q == ST_ABSORB) || (state_q == ST_ROUND);
    assign digest_valid = (state_q == ST_DONE);
    assign digest       = h_q;

endmodule

// File: tb/tb_hash_round_engine.sv
// -----------------------------------------------------------------------------
// tb_hash_round_engine
//
// Two engines: A (ROUNDS=16, default IV) is driven from a message table with a
// digest scoreboard; B (ROUNDS=1, IV=0) is driven from hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_hash_round_engine;

    localparam int          ROUNDS_A  = 16;
    localparam logic [31:0] IV_A      = 32'h0123_4567;
    localparam logic [63:0] SBOX_TBL  = 64'h2174_8FE3_DA09_B65C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, mv_a, ml_a, rdy_a, busy_a, dv_a;
    logic [7:0]  md_a;
    logic [31:0] dig_a;
    logic        start_b, mv_b, ml_b, rdy_b, busy_b, dv_b;
    logic [7:0]  md_b;
    logic [31:0] dig_b;

    hash_round_engine #(.ROUNDS(ROUNDS_A), .IV(IV_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .msg_valid(mv_a),
        .msg_data(md_a), .msg_last(ml_a), .msg_ready(rdy_a), .busy(busy_a),
        .digest(dig_a), .digest_valid(dv_a)
    );

    hash_round_engine #(.ROUNDS(1), .IV(32'h0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .msg_valid(mv_b),
        .msg_data(md_b), .msg_last(ml_b), .msg_ready(rdy_b), .busy(busy_b),
        .digest(dig_b), .digest_valid(dv_b)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] sb_q[$];
    logic [31:0] exp_m;
    logic        dv_a_prev = 1'b0;

    typedef struct {
        logic [63:0] m;
        int          n;
        logic [31:0] exp;
    } vec_b_t;

    typedef struct {
        logic [63:0] m;
        int          n;
        int          gap;
        logic [31:0] exp;
    } vec_a_t;

    vec_b_t tbl_b[3];
    vec_a_t tbl_a[7];
    int     acc[8];
    int     low[8];
    int     lat;
    int     t;
    logic [63:0] pmsg;
    logic [31:0] pexp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Reference digest straight from the S-box table and round equation.
    function automatic logic [31:0] model(input logic [31:0] iv, input int rounds,
                                          input logic [63:0] m, input int n);
        logic [3:0]  h[8];
        logic [3:0]  hn[8];
        logic [3:0]  mr, s, x;
        logic [7:0]  bt;
        logic [63:0] tbl;
        logic [31:0] r;
        tbl = SBOX_TBL;
        for (int i = 0; i < 8; i++) h[i] = iv[4*i +: 4];
        for (int b = 0; b < n; b++) begin
            bt = m[8*b +: 8];
            for (int k = 0; k < rounds; k++) begin
                mr = (k % 2 == 1) ? bt[7:4] : bt[3:0];
                s  = tbl[{h[0] ^ mr, 2'b00} +: 4];
                for (int i = 0; i < 8; i++) begin
                    x = h[(i + 2) % 8] ^ s;
                    for (int j = 0; j < i / 2; j++) x = {x[2:0], x[3]};
                    hn[i] = x;
                end
                h = hn;
            end
        end
        for (int i = 0; i < 8; i++) r[4*i +: 4] = h[i];
        return r;
    endfunction

    // Scoreboard: each rising digest_valid on A retires one expected digest.
    always @(negedge clk) begin
        if (rst_n && dv_a && !dv_a_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL digest_unexpected actual=%h required=none", dig_a);
            end else begin
                exp_m = sb_q.pop_front();
                check("digest_a", dig_a, exp_m);
            end
        end
        dv_a_prev = dv_a;
    end

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [63:0] m, input int n, input int max_gap,
                          input logic [31:0] exp);
        int tt;
        sb_q.push_back(exp);
        for (int b = 0; b < n; b++) begin
            if (max_gap > 0) begin
                mv_a = 1'b0;
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            mv_a = 1'b1;
            md_a = m[8*b +: 8];
            ml_a = (b == n - 1);
            tt = 0;
            while (!rdy_a && tt < 200) begin
                @(negedge clk);
                tt++;
            end
            if (!rdy_a) begin
                fail_timeout("accept_a");
                mv_a = 1'b0;
                return;
            end
            @(negedge clk);
            acc[b] = cyc;
            low[b] = 0;
            if (b != n - 1) begin
                while (!rdy_a && low[b] < 200) begin
                    @(negedge clk);
                    low[b]++;
                end
            end
        end
        mv_a = 1'b0;
        ml_a = 1'b0;
    endtask

    task automatic wait_dv_a();
        int tt;
        tt = 0;
        while (!dv_a && tt < 1000) begin
            @(negedge clk);
            tt++;
        end
        if (!dv_a) fail_timeout("digest_valid_a");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; mv_a = 1'b0; ml_a = 1'b0; md_a = 8'h00;
        start_b = 1'b0; mv_b = 1'b0; ml_b = 1'b0; md_b = 8'h00;

        // Hand-derived single-round vectors with IV = 0.
        tbl_b[0] = '{m: 64'h00,   n: 1, exp: 32'h6633_99CC};
        tbl_b[1] = '{m: 64'h01,   n: 1, exp: 32'hAA55_AA55};
        tbl_b[2] = '{m: 64'h0000, n: 2, exp: 32'h4488_EEDD};

        tbl_a[0] = '{m: 64'h00_00_00_00_00_C3_5A_17, n: 3, gap: 0, exp: 32'h0};
        tbl_a[1] = tbl_a[0];
        for (int i = 2; i < 7; i++) begin
            tbl_a[i].m   = {$urandom(), $urandom()};
            tbl_a[i].n   = $urandom_range(1, 8);
            tbl_a[i].gap = 3;
        end
        for (int i = 0; i < 7; i++) tbl_a[i].exp = model(IV_A, ROUNDS_A, tbl_a[i].m, tbl_a[i].n);

        repeat (3) @(negedge clk);
        check("rst_ready_a",  32'(rdy_a),  32'd0);
        check("rst_busy_a",   32'(busy_a), 32'd0);
        check("rst_dv_a",     32'(dv_a),   32'd0);
        check("rst_digest_a", dig_a,       32'd0);
        check("rst_dv_b",     32'(dv_b),   32'd0);
        check("rst_digest_b", dig_b,       32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy_a",  32'(busy_a), 32'd0);
        check("idle_ready_a", 32'(rdy_a),  32'd0);

        // start and msg_valid together in IDLE: only the IV load happens.
        start_a = 1'b1; mv_a = 1'b1; md_a = 8'hA5; ml_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; mv_a = 1'b0; ml_a = 1'b0;
        check("idle_start_ready", 32'(rdy_a), 32'd1);
        check("idle_start_h",     dig_a,      IV_A);
        check("idle_start_dv",    32'(dv_a),  32'd0);

        // Engine B: one round per byte, digest exactly one cycle after accept.
        for (int e = 0; e < 3; e++) begin
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            check("b_start_h",     dig_b,      32'd0);
            check("b_start_dv",    32'(dv_b),  32'd0);
            check("b_start_ready", 32'(rdy_b), 32'd1);
            for (int k = 0; k < tbl_b[e].n; k++) begin
                mv_b = 1'b1;
                md_b = tbl_b[e].m[8*k +: 8];
                ml_b = (k == tbl_b[e].n - 1);
                t = 0;
                while (!rdy_b && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (!rdy_b) fail_timeout("accept_b");
                @(negedge clk);
                mv_b = 1'b0;
                ml_b = 1'b0;
            end
            check("b_dv_early", 32'(dv_b), 32'd0);
            @(negedge clk);
            check("b_dv",     32'(dv_b), 32'd1);
            check("b_digest", dig_b,     tbl_b[e].exp);
        end

        // Engine A: table of messages; entry 0 holds msg_valid high throughout.
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin
                pulse_start_a();
                check("a_restart_dv", 32'(dv_a), 32'd0);
                check("a_restart_h",  dig_a,     IV_A);
            end
            send_a(tbl_a[i].m, tbl_a[i].n, tbl_a[i].gap, tbl_a[i].exp);
            wait_dv_a();
            lat = cyc - acc[tbl_a[i].n - 1];
            check("a_latency", 32'(lat), 32'd16);
            if (i == 0) begin
                check("a_accept_gap0", 32'(acc[1] - acc[0]), 32'd17);
                check("a_accept_gap1", 32'(acc[2] - acc[1]), 32'd17);
                check("a_ready_low0",  32'(low[0]),          32'd16);
                check("a_ready_low1",  32'(low[1]),          32'd16);
            end
        end

        // msg_valid in DONE must not disturb the held digest.
        mv_a = 1'b1; md_a = 8'h3C; ml_a = 1'b1;
        repeat (3) @(negedge clk);
        mv_a = 1'b0; ml_a = 1'b0;
        check("done_hold_dv",     32'(dv_a),  32'd1);
        check("done_hold_digest", dig_a,      tbl_a[6].exp);
        check("done_hold_ready",  32'(rdy_a), 32'd0);

        // start pulsed mid-ROUND is ignored: digest equals the plain model run.
        pmsg = 64'h0000_0000_0000_9E41;
        pexp = model(IV_A, ROUNDS_A, pmsg, 2);
        pulse_start_a();
        fork
            send_a(pmsg, 2, 0, pexp);
            begin
                t = 0;
                while (!(busy_a && !rdy_a) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                repeat (3) @(negedge clk);
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
        join
        wait_dv_a();

        // Asynchronous reset in the middle of ROUND.
        pulse_start_a();
        mv_a = 1'b1; md_a = 8'h77; ml_a = 1'b0;
        t = 0;
        while (!rdy_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        mv_a = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 32'(busy_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(busy_a), 32'd0);
        check("async_rst_ready",  32'(rdy_a),  32'd0);
        check("async_rst_dv",     32'(dv_a),   32'd0);
        check("async_rst_digest", dig_a,       32'd0);
        check("async_rst_dv_b",   32'(dv_b),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy",  32'(busy_a), 32'd0);
        check("post_rst_ready", 32'(rdy_a),  32'd0);
        check("post_rst_dv",    32'(dv_a),   32'd0);

        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
